// File: rtl/ysyx_22041211_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_ifu_if : fetch-unit bundle (memory port, redirect, decode port)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ysyx_22041211_ifu_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_LEN-1:0] mem_req_addr;
  logic                mem_rsp_valid;
  logic [DATA_LEN-1:0] mem_rsp_data;
  logic                mem_rsp_err;
  logic                redirect_valid;
  logic [ADDR_LEN-1:0] redirect_pc;
  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_LEN-1:0] inst;
  logic [ADDR_LEN-1:0] inst_pc;
  logic                inst_fault;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22041211_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_ifu : instruction fetch unit, one outstanding request, redirects
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_22041211_ifu #(
  parameter int                  ADDR_LEN = 32,
  parameter int                  DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22041211_ifu_if.master bus
);

  localparam logic [DATA_LEN-1:0] C_NOP = DATA_LEN'(32'h00000013);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [ADDR_LEN-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic                fault_q, fault_d;
  logic                live_q;
  logic                w_accept;
  logic                w_land;

  // live_q keeps the request low until the first edge after reset release
  assign bus.mem_req_valid = live_q && (state_q == S_REQ);
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == S_HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_fault    = fault_q;

  assign w_accept = bus.mem_req_valid && bus.mem_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_pc_q <= '0;
      inst_q    <= '0;
      fault_q   <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      fault_q   <= fault_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    w_land    = 1'b0;

    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (w_accept) state_d = S_DROP;
          else          w_land  = 1'b1;
        end else if (w_accept) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.mem_rsp_valid) w_land  = 1'b1;
          else                   state_d = S_DROP;
        end else if (bus.mem_rsp_valid) begin
          state_d   = S_HOLD;
          inst_pc_d = pc_q;
          inst_d    = bus.mem_rsp_err ? C_NOP : bus.mem_rsp_data;
          fault_d   = bus.mem_rsp_err;
        end
      end
      // A redirect landing on the stale beat consumes it; waiting for another would hang
      S_DROP: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (bus.mem_rsp_valid)  w_land = 1'b1;
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d   = bus.redirect_pc;
          w_land = 1'b1;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + ADDR_LEN'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // With nothing outstanding, a misaligned target is reported instead of fetched
    if (w_land) begin
      if (|pc_d[1:0]) begin
        state_d   = S_HOLD;
        inst_pc_d = pc_d;
        inst_d    = C_NOP;
        fault_d   = 1'b1;
      end else begin
        state_d = S_REQ;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041211_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041211_ifu : vector table, directed corner sequences, random fetch
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_22041211_ifu;

  localparam logic [31:0] C_RESET_PC = 32'h80000000;
  localparam logic [31:0] C_NOP      = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ysyx_22041211_ifu_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  ysyx_22041211_ifu #(
    .ADDR_LEN(32),
    .DATA_LEN(32),
    .RESET_PC(32'h80000000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        rsp_e;
    logic        red_v;
    logic [31:0] red_pc;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_fault;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  dly;
  } pend_t;

  vec_t  tbl [30];
  pend_t q[$];

  function automatic vec_t mk(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                              input logic rsp_e, input logic red_v, input logic [31:0] red_pc,
                              input logic irdy, input logic e_rv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_ipc,
                              input logic e_fault);
    vec_t v;
    v = '{rdy, rsp_v, rsp_d, rsp_e, red_v, red_pc, irdy, e_rv, e_addr, e_iv, e_inst, e_ipc, e_fault};
    return v;
  endfunction

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic memerr(input logic [31:0] a);
    return (a[6:2] == 5'd9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                       input logic rsp_e, input logic red_v, input logic [31:0] red_pc,
                       input logic irdy);
    bus.mem_req_ready  = rdy;
    bus.mem_rsp_valid  = rsp_v;
    bus.mem_rsp_data   = rsp_d;
    bus.mem_rsp_err    = rsp_e;
    bus.redirect_valid = red_v;
    bus.redirect_pc    = red_pc;
    bus.inst_ready     = irdy;
  endtask

  task automatic cyc(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                     input logic rsp_e, input logic red_v, input logic [31:0] red_pc,
                     input logic irdy);
    @(negedge clk);
    drive(rdy, rsp_v, rsp_d, rsp_e, red_v, red_pc, irdy);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, ".inst"}, bus.inst, 32'd0);
    chk({tag, ".inst_pc"}, bus.inst_pc, 32'd0);
    chk({tag, ".inst_fault"}, 32'(bus.inst_fault), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] model_pc, rpc, prev_inst, prev_ipc, exp_inst, cur_addr;
    logic        mis, prev_hold, prev_fault, rdy, irdy, redv, rspv, accept, exp_fault;
    int          idle;
    pend_t       head;

    drive(0, 0, 0, 0, 0, 0, 0);

    // ---------------- reset and vector table ----------------
    tbl[0]  = mk(1, 0, 0,            0, 0, 0,            0, 1, 32'h80000000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 32'h00100093, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,            1, 0, 0,            1, 32'h00100093, 32'h80000000, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,            0, 1, 32'h80000004, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0,            0, 0, 0,            0, 1, 32'h80000004, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 32'h00208113, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    for (int i = 7; i < 12; i++)
      tbl[i] = mk(1, 0, 0,           0, 0, 0,            0, 0, 0,            1, 32'h00208113, 32'h80000004, 0);
    tbl[12] = mk(1, 0, 0,            0, 0, 0,            1, 0, 0,            1, 32'h00208113, 32'h80000004, 0);
    tbl[13] = mk(1, 0, 0,            0, 0, 0,            0, 1, 32'h80000008, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,            0, 1, 32'h80000100, 0, 0, 0,            0, 0, 0, 0);
    tbl[15] = mk(0, 1, 32'hDEADBEEF, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0,            0, 0, 0,            0, 1, 32'h80000100, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 32'h12345678, 1, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0,            0, 1, 32'h80000200, 1, 0, 0,            1, C_NOP, 32'h80000100, 1);
    tbl[19] = mk(0, 0, 0,            0, 1, 32'h80000102, 0, 1, 32'h80000200, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0,            0, 0, 0,            0, 0, 0,            1, C_NOP, 32'h80000102, 1);
    tbl[21] = mk(0, 0, 0,            0, 0, 0,            1, 0, 0,            1, C_NOP, 32'h80000102, 1);
    tbl[22] = mk(0, 0, 0,            0, 1, 32'h80000000, 0, 1, 32'h80000106, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0,            0, 0, 0,            0, 1, 32'h80000000, 0, 0, 0, 0);
    tbl[24] = mk(0, 1, 32'hCAFEF00D, 0, 1, 32'h80000300, 0, 0, 0,            0, 0, 0, 0);
    tbl[25] = mk(0, 0, 0,            0, 0, 0,            0, 1, 32'h80000300, 0, 0, 0, 0);
    tbl[26] = mk(1, 0, 0,            0, 1, 32'h80000400, 0, 1, 32'h80000300, 0, 0, 0, 0);
    tbl[27] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    tbl[28] = mk(0, 1, 32'h0BADF00D, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0);
    tbl[29] = mk(0, 0, 0,            0, 0, 0,            0, 1, 32'h80000400, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release.req_valid", 32'(bus.mem_req_valid), 32'd0);

    for (int i = 0; i < 30; i++) begin
      cyc(tbl[i].rdy, tbl[i].rsp_v, tbl[i].rsp_d, tbl[i].rsp_e, tbl[i].red_v, tbl[i].red_pc, tbl[i].irdy);
      chk($sformatf("vec%0d.req_valid", i), 32'(bus.mem_req_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("vec%0d.req_addr", i), bus.mem_req_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d.inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d.inst", i), bus.inst, tbl[i].e_inst);
        chk($sformatf("vec%0d.inst_pc", i), bus.inst_pc, tbl[i].e_ipc);
        chk($sformatf("vec%0d.inst_fault", i), 32'(bus.inst_fault), 32'(tbl[i].e_fault));
      end
    end

    // ---------------- reset in WAIT, late response ----------------
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    chk("postrst0.req_valid", 32'(bus.mem_req_valid), 32'd0);
    cyc(0, 1, 32'hFEEDFACE, 0, 0, 0, 0);
    chk("postrst1.req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("postrst1.req_addr", bus.mem_req_addr, C_RESET_PC);
    chk("postrst1.inst_valid", 32'(bus.inst_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("postrst2.inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("postrst2.req_addr", bus.mem_req_addr, C_RESET_PC);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h00300193, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("postrst.inst", bus.inst, 32'h00300193);
    chk("postrst.inst_pc", bus.inst_pc, C_RESET_PC);

    // ---------------- pc wraps past the top of the address space ----------------
    cyc(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrap.req_addr", bus.mem_req_addr, 32'hFFFFFFFC);
    cyc(0, 1, 32'h00000073, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap.inst_pc", bus.inst_pc, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap.next_addr", bus.mem_req_addr, 32'h00000000);

    // ---------------- misaligned redirect with a request outstanding ----------------
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h80000002, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("misdrop.req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("misdrop.inst_valid", 32'(bus.inst_valid), 32'd0);
    cyc(0, 1, 32'h11111111, 0, 0, 0, 0);
    chk("misdrop2.inst_valid", 32'(bus.inst_valid), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("mis.inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("mis.inst", bus.inst, C_NOP);
    chk("mis.inst_pc", bus.inst_pc, 32'h80000002);
    chk("mis.inst_fault", 32'(bus.inst_fault), 32'd1);
    chk("mis.req_valid", 32'(bus.mem_req_valid), 32'd0);

    // ---------------- randomized traffic against a transaction model ----------------
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_pc   = C_RESET_PC;
    mis        = 1'b0;
    prev_hold  = 1'b0;
    prev_inst  = '0;
    prev_ipc   = '0;
    prev_fault = 1'b0;
    idle       = 0;
    q.delete();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rspv     = 1'b0;
      cur_addr = '0;
      if (q.size() > 0 && q[0].dly == 2'd0) begin
        rspv     = 1'b1;
        cur_addr = q[0].addr;
      end
      rdy  = ($urandom_range(0, 2) != 0);
      irdy = ($urandom_range(0, 3) != 0);
      redv = ($urandom_range(0, 15) == 0);
      rpc  = C_RESET_PC + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      drive(rdy, rspv, memdata(cur_addr), memerr(cur_addr), redv, rpc, irdy);
      #1;

      chk("rnd.req_in_hold", 32'(bus.mem_req_valid && bus.inst_valid), 32'd0);
      if (prev_hold) begin
        chk("rnd.hold_valid", 32'(bus.inst_valid), 32'd1);
        chk("rnd.hold_inst", bus.inst, prev_inst);
        chk("rnd.hold_pc", bus.inst_pc, prev_ipc);
        chk("rnd.hold_fault", 32'(bus.inst_fault), 32'(prev_fault));
      end

      accept = bus.mem_req_valid && rdy;
      if (accept) begin
        chk("rnd.outstanding", 32'(q.size()) - 32'(rspv), 32'd0);
        chk("rnd.req_addr", bus.mem_req_addr, model_pc);
      end

      idle++;
      if (redv) begin
        model_pc = rpc;
        mis      = |rpc[1:0];
      end else if (bus.inst_valid && irdy) begin
        if (mis || memerr(model_pc)) begin
          exp_inst  = C_NOP;
          exp_fault = 1'b1;
        end else begin
          exp_inst  = memdata(model_pc);
          exp_fault = 1'b0;
        end
        chk("rnd.inst_pc", bus.inst_pc, model_pc);
        chk("rnd.inst", bus.inst, exp_inst);
        chk("rnd.inst_fault", 32'(bus.inst_fault), 32'(exp_fault));
        model_pc = model_pc + 32'd4;
        mis      = 1'b0;
        idle     = 0;
      end

      prev_hold  = bus.inst_valid && !irdy && !redv;
      prev_inst  = bus.inst;
      prev_ipc   = bus.inst_pc;
      prev_fault = bus.inst_fault;

      if (rspv) begin
        void'(q.pop_front());
      end else if (q.size() > 0) begin
        head     = q[0];
        head.dly = head.dly - 2'd1;
        q[0]     = head;
      end
      if (accept) q.push_back('{addr: bus.mem_req_addr, dly: 2'($urandom_range(0, 2))});

      if (idle > 200) begin
        chk("rnd.progress", 32'(idle), 32'd0);
        break;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22041211_ifu.md
YSYX_22041211_IFU -- requirements
Module: ysyx_22041211_IFU

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDR_LEN  32  address width
  DATA_LEN  32  instruction width
  RESET_PC  32'h80000000  first fetch address
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on posedge
  rst  in  1  reset, asynchronous, active-low
  mem_req_valid  out  1  fetch request valid
  mem_req_ready  in  1  memory accepts request
  mem_req_addr  out  ADDR_LEN  fetch address
  mem_rsp_valid  in  1  response valid
  mem_rsp_data  in  DATA_LEN  fetched word
  mem_rsp_err  in  1  access fault on response
  redirect_valid  in  1  branch/jump redirect from execute
  redirect_pc  in  ADDR_LEN  redirect target
  inst_valid  out  1  instruction available to decode
  inst_ready  in  1  decode consumes instruction
  inst  out  DATA_LEN  instruction word
  inst_pc  out  ADDR_LEN  PC of inst
  inst_fault  out  1  fetch fault or misaligned target

Function
REQ-003 The block SHALL hold a PC register and a 4-state FSM: REQ, WAIT, DROP, HOLD.
REQ-004 In REQ, the block SHALL drive mem_req_valid=1 and mem_req_addr=pc; on mem_req_valid&mem_req_ready it SHALL enter WAIT.
REQ-005 mem_req_addr SHALL stay stable until accepted, except when a redirect occurs in REQ.
REQ-006 In WAIT, on mem_rsp_valid the block SHALL capture mem_rsp_data and mem_rsp_err and enter HOLD.
REQ-007 mem_rsp_valid SHALL be ignored in REQ and HOLD.
REQ-008 In HOLD, the block SHALL assert inst_valid with inst, inst_pc=pc, and inst_fault held stable until inst_ready.
REQ-009 On inst_valid&inst_ready without redirect, the block SHALL set pc<=pc+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0) and enter REQ.
REQ-010 Minimum latency SHALL be: request accept at cycle N, response at N+1, inst_valid at N+2.
REQ-011 On mem_rsp_err, the block SHALL present inst=32'h00000013 with inst_fault=1.
REQ-012 redirect_valid SHALL have priority over every other event in every state, and SHALL load pc<=redirect_pc.
REQ-013 Redirect in REQ without accept: stay in REQ, with the new address driven the next cycle.
REQ-014 Redirect in REQ with accept in the same cycle: enter DROP.
REQ-015 Redirect in WAIT without mem_rsp_valid: enter DROP.
REQ-016 Redirect in WAIT with mem_rsp_valid: discard the response and enter REQ.
REQ-017 Redirect in DROP: stay in DROP.
REQ-018 Redirect in HOLD, including the cycle of inst_ready: discard the held instruction, deassert inst_valid the next cycle, do not add 4 to pc, and enter REQ.
REQ-019 In DROP, the block SHALL discard the next mem_rsp_valid beat and then enter REQ; inst_valid SHALL stay 0.
REQ-020 A redirect_pc with bits[1:0]!=0 SHALL go directly to HOLD with inst=32'h00000013 and inst_fault=1, with no memory request issued.
REQ-020a Exception to REQ-020: if a request is outstanding, the block SHALL first pass through DROP.
REQ-021 At most one request SHALL be outstanding at any time.

Reset
REQ-022 While rst=0, the block SHALL hold: pc=RESET_PC, state=REQ, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
REQ-023 On the first clk edge after rst rises, mem_req_valid SHALL be 1 with mem_req_addr=RESET_PC.
REQ-024 Reset asserted mid-transaction SHALL abandon all state immediately; a response from before the reset that arrives afterwards SHALL be ignored (REQ-007).

Verification
REQ-025 Nominal fetch: ready=1, response returns 32'h00100093 one cycle after accept -> inst_valid with inst_pc=32'h80000000, then the next request goes to 32'h80000004.
REQ-026 Backpressure: inst_ready=0 for 5 cycles -> inst, inst_pc, and inst_fault stay constant, with no new request; the next request is issued after inst_ready.
REQ-027 Redirect in WAIT to 32'h80000100 -> the stale response is dropped and not presented; the next request goes to 32'h80000100.
REQ-028 Redirect to 32'h80000102 -> no request issued; inst_fault=1, inst=32'h00000013, inst_pc=32'h80000102.
REQ-029 mem_rsp_err=1 -> inst_fault=1 with inst=32'h00000013; redirect in the same cycle as inst_ready -> pc=redirect_pc, not pc+4.
REQ-030 rst pulsed low while in WAIT, response arrives afterwards -> response ignored; the request re-issues to 32'h80000000.
